bit_stuffer: RTL and testbench



---
 rtl/bit_stuffer.sv | 117 +++++++++++
 tb/tb_bit_stuffer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bit_stuffer.sv
`default_nettype none
// ============================================================================
// Module      : bit_stuffer
// Description : Serial bit stuffer; inserts a 0 after six consecutive 1s and
//               back-pressures the upstream CRC stage for the inserted cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_stuffer (
    input  logic clk,
    input  logic rst,
    input  logic s_in,
    input  logic start,
    input  logic endr,
    output logic pause,
    output logic s_out,
    output logic out_valid,
    output logic start_o,
    output logic endr_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STUFF  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] ones_cnt_q, ones_cnt_d;
    logic       end_pend_q, end_pend_d;
    logic       pause_q, pause_d;
    logic       s_out_q, s_out_d;
    logic       out_valid_q, out_valid_d;
    logic       start_o_q, start_o_d;
    logic       endr_o_q, endr_o_d;
    logic       consume;
    logic [2:0] ones_next;

    always_comb begin
        state_d     = state_q;
        ones_cnt_d  = ones_cnt_q;
        end_pend_d  = 1'b0;
        pause_d     = 1'b0;
        s_out_d     = 1'b0;
        out_valid_d = 1'b0;
        start_o_d   = 1'b0;
        endr_o_d    = 1'b0;
        consume     = ((state_q == IDLE) && start) || (state_q == ACTIVE);
        // A start (first bit or abort) restarts the run count before its own bit.
        ones_next   = 3'd0;
        if (s_in) begin
            ones_next = (start ? 3'd0 : ones_cnt_q) + 3'd1;
        end

        case (state_q)
            STUFF: begin
                // Upstream is held this cycle; emit the inserted 0 instead.
                s_out_d     = 1'b0;
                out_valid_d = 1'b1;
                endr_o_d    = end_pend_q;
                ones_cnt_d  = 3'd0;
                state_d     = end_pend_q ? IDLE : ACTIVE;
            end
            default: begin
                if (consume) begin
                    s_out_d     = s_in;
                    out_valid_d = 1'b1;
                    start_o_d   = start;
                    ones_cnt_d  = ones_next;
                    if (ones_next == 3'd6) begin
                        // End marker moves onto the stuffed 0 that follows.
                        state_d    = STUFF;
                        pause_d    = 1'b1;
                        end_pend_d = endr;
                    end else if (endr) begin
                        state_d    = IDLE;
                        endr_o_d   = 1'b1;
                        ones_cnt_d = 3'd0;
                    end else begin
                        state_d    = ACTIVE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ones_cnt_q  <= 3'd0;
            end_pend_q  <= 1'b0;
            pause_q     <= 1'b0;
            s_out_q     <= 1'b0;
            out_valid_q <= 1'b0;
            start_o_q   <= 1'b0;
            endr_o_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ones_cnt_q  <= ones_cnt_d;
            end_pend_q  <= end_pend_d;
            pause_q     <= pause_d;
            s_out_q     <= s_out_d;
            out_valid_q <= out_valid_d;
            start_o_q   <= start_o_d;
            endr_o_q    <= endr_o_d;
        end
    end

    assign pause     = pause_q;
    assign s_out     = s_out_q;
    assign out_valid = out_valid_q;
    assign start_o   = start_o_q;
    assign endr_o    = endr_o_q;

endmodule
`default_nettype wire

// File: tb/tb_bit_stuffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_stuffer
// Description : Self-checking bench for bit_stuffer (vector table, directed
//               streams and random streams against a stream-level model).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bit_stuffer;

    logic clk = 1'b0;
    logic rst, s_in, start, endr;
    logic pause, s_out, out_valid, start_o, endr_o;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    bit_stuffer dut (
        .clk      (clk),
        .rst      (rst),
        .s_in     (s_in),
        .start    (start),
        .endr     (endr),
        .pause    (pause),
        .s_out    (s_out),
        .out_valid(out_valid),
        .start_o  (start_o),
        .endr_o   (endr_o)
    );

    typedef struct packed {
        logic s;
        logic st;
        logic en;
    } in_t;

    // exp packs {out_valid, s_out, start_o, endr_o, pause}
    typedef struct {
        in_t        in;
        logic [4:0] exp;
    } vec_t;

    vec_t       tbl[10];
    in_t        stim[$];
    logic [4:0] olog[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] outs();
        return {out_valid, s_out, start_o, endr_o, pause};
    endfunction

    task automatic drive(input in_t v);
        {s_in, start, endr} = v;
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) stim.push_back(in_t'(3'b000));
    endtask

    task automatic add_pkt(input logic [63:0] bits, input int len, input bit with_end);
        for (int i = 0; i < len; i++)
            stim.push_back(in_t'({bits[i], (i == 0), (with_end && (i == len - 1))}));
    endtask

    // Plays stim honoring pause, then compares against the stream-level model.
    task automatic run_stream(input string name, input bit contig);
        logic [2:0] expq[$];
        logic [2:0] gotq[$];
        int ones = 0, nstuff = 0, first_start = -1, npause = 0, viol = 0;
        int first_v = -1, last_v = -1;
        bit inpkt = 0;
        int idx = 0, cyc = 0, drain = 0;
        int n = stim.size();

        foreach (stim[k]) begin
            if (stim[k].st) begin
                inpkt = 1;
                ones  = 0;
                if (first_start < 0) first_start = k;
            end
            if (!inpkt) continue;
            ones = stim[k].s ? ones + 1 : 0;
            expq.push_back({stim[k].s, stim[k].st, stim[k].en && (ones != 6)});
            if (ones == 6) begin
                expq.push_back({1'b0, 1'b0, stim[k].en});
                ones = 0;
                nstuff++;
            end
            if (stim[k].en) inpkt = 0;
        end

        olog.delete();
        drive(stim[0]);
        while (drain < 4) begin
            @(posedge clk); #1;
            olog.push_back(outs());
            cyc++;
            if (!pause && idx < n) idx++;
            if (idx < n) drive(stim[idx]);
            else drive(in_t'(3'b000));
            if (idx >= n) drain++;
            if (cyc > 2 * n + 20) begin
                check({name, " timeout"}, 32'd1, 32'd0);
                break;
            end
        end

        foreach (olog[k]) begin
            if (olog[k][4]) begin
                gotq.push_back(olog[k][3:1]);
                if (first_v < 0) first_v = k;
                last_v = k;
            end else if (olog[k][3:0] != 4'd0) begin
                viol++;
            end
            if (olog[k][0]) begin
                npause++;
                if (!(olog[k][4] && olog[k][3])) viol++;
            end
        end

        check({name, " out_count"}, gotq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < gotq.size(); i++)
            check($sformatf("%s bit%0d {s,so,eo}", name, i), {29'd0, gotq[i]}, {29'd0, expq[i]});
        check({name, " pause_count"}, npause, nstuff);
        check({name, " idle_clean"}, viol, 0);
        if (first_start >= 0 && first_start < olog.size())
            check({name, " first_latency"}, {30'd0, olog[first_start][4], olog[first_start][2]}, 32'd3);
        if (contig && first_v >= 0)
            check({name, " contiguous"}, last_v - first_v + 1, gotq.size());
        stim.delete();
    endtask

    initial begin
        // Six-ones stuff, cycle by cycle; rows 6/7 are the 7th bit held during pause.
        tbl[0] = '{in_t'(3'b110), 5'b11100};
        for (int i = 1; i <= 4; i++) tbl[i] = '{in_t'(3'b100), 5'b11000};
        tbl[5] = '{in_t'(3'b100), 5'b11001};
        tbl[6] = '{in_t'(3'b000), 5'b10000};
        tbl[7] = '{in_t'(3'b000), 5'b10000};
        tbl[8] = '{in_t'(3'b001), 5'b10010};
        tbl[9] = '{in_t'(3'b000), 5'b00000};

        rst = 1'b1;
        drive(in_t'(3'b000));
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {27'd0, outs()}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].in);
            @(posedge clk); #1;
            check($sformatf("six_ones row%0d", i), {27'd0, outs()}, {27'd0, tbl[i].exp});
        end

        add_idle(2); add_pkt(64'h0FFF, 13, 1'b1); add_idle(2);
        run_stream("double_stuff", 1'b1);

        add_idle(2); add_pkt(64'h7E, 7, 1'b1); add_idle(2);
        run_stream("trailing_stuff", 1'b1);

        // Sync byte sent LSB first, then five 1s and a 0.
        add_idle(2); add_pkt(64'h1F01, 14, 1'b1); add_idle(2);
        run_stream("no_stuff", 1'b1);

        add_idle(2); add_pkt(64'hF, 4, 1'b0); add_pkt(64'h17, 5, 1'b1); add_idle(2);
        run_stream("restart", 1'b0);

        add_idle(1); add_pkt(64'h1, 1, 1'b1); add_idle(1); add_pkt(64'h3F, 6, 1'b1); add_idle(2);
        run_stream("single_and_end_stuff", 1'b0);

        // Reset abort mid-packet.
        drive(in_t'(3'b110));
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            drive(in_t'({i[0], 2'b00}));
            @(posedge clk); #1;
        end
        check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        #2 rst = 1'b1;
        #1 check("async_reset_outputs", {27'd0, outs()}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(in_t'(3'b000));
        repeat (2) begin
            @(posedge clk); #1;
            check("post_reset_idle", {27'd0, outs()}, 32'd0);
        end
        drive(in_t'(3'b111));
        @(posedge clk); #1;
        check("post_reset_one_bit", {27'd0, outs()}, 32'b11110);
        drive(in_t'(3'b000));
        @(posedge clk); #1;
        check("post_reset_return_idle", {27'd0, outs()}, 32'd0);

        for (int r = 0; r < 25; r++) begin
            int npk;
            npk = $urandom_range(1, 4);
            add_idle($urandom_range(0, 2));
            for (int p = 0; p < npk; p++) begin
                logic [63:0] bits;
                int len;
                bit with_end;
                len = $urandom_range(1, 24);
                bits = '0;
                for (int b = 0; b < len; b++) bits[b] = ($urandom_range(0, 3) != 0);
                with_end = (p == npk - 1) || ($urandom_range(0, 3) != 0);
                add_pkt(bits, len, with_end);
                if (with_end) add_idle($urandom_range(0, 3));
            end
            add_idle(2);
            run_stream($sformatf("random%0d", r), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
